div_reconstruct: RTL and testbench

//  Sequential inverse of the 8-bit divider: rebuilds dividend = quo*divisor + rem

---
 rtl/div_reconstruct.sv | 176 +++++++++++++++++
 tb/tb_div_reconstruct.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct.sv
// ---------------------------------------------------------------------------
// div_reconstruct
//   Sequential inverse of the WIDTH-bit divider: rebuilds
//   dividend = quo * divisor + rem with a shift-add multiplier that retires
//   one partial product per clock.  It is used as a MUL-with-addend operation
//   and as a self-check of divider outputs.
//
//   Handshake: start is sampled only in IDLE.  busy is high in RUN and DONE.
//   done pulses for one cycle.  result is valid from that cycle and is held
//   until the next operation completes.
//
//   Latency is fixed: start accepted at edge 0, WIDTH RUN edges follow, done
//   is high in the cycle after edge WIDTH, and the next start can be accepted
//   at edge WIDTH+2 at the earliest.  There is no early termination.
//
// Optional feature (compile-time macro DIVCHK_OVF_EN):
//   When defined, an extra output ovf is present.  It is registered together
//   with result and flags a result that does not fit in WIDTH bits, or an
//   illegal remainder (rem >= divisor, which includes divisor == 0).
//
// Ports
//   clk      in   1          rising-edge clock
//   rst      in   1          asynchronous active-high reset
//   start    in   1          operation request (sampled in IDLE only)
//   quo      in   WIDTH      multiplier (quotient), captured on accept
//   divisor  in   WIDTH      multiplicand, captured on accept
//   rem      in   WIDTH      addend (remainder), captured on accept
//   busy     out  1          high in RUN and DONE
//   done     out  1          one-cycle completion pulse
//   result   out  2*WIDTH    quo*divisor + rem
//   ovf      out  1          only with DIVCHK_OVF_EN
// ---------------------------------------------------------------------------
module div_reconstruct #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quo,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     rem,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
`ifdef DIVCHK_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_result;

    logic                  w_accept;
    logic                  w_last;
    logic [2*WIDTH-1:0]    w_acc_next;

    assign w_accept = (r_state == S_IDLE) && start;
    // The final RUN edge is the one that processes multiplier bit WIDTH-1.
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    // Accumulator is 2*WIDTH wide: (2^W-1)^2 + 2^W-1 < 2^(2W), so no carry out.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift-add datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            // The remainder seeds the accumulator, so the addend costs no cycle.
            r_acc    <= {{WIDTH{1'b0}}, rem};
            r_mcand  <= {{WIDTH{1'b0}}, divisor};
            r_mplier <= quo;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign result = r_result;

`ifdef DIVCHK_OVF_EN
    // -----------------------------------------------------------------------
    // Overflow / illegal-remainder flag, judged on the operands captured at
    // start so that inputs may change freely during the run.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_ovf;
    logic             w_ovf_next;

    assign w_ovf_next = (w_acc_next[2*WIDTH-1:WIDTH] != '0) || (r_rem >= r_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_rem <= rem;
            r_div <= divisor;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_div_reconstruct.sv
// ---------------------------------------------------------------------------
// tb_div_reconstruct
//   Scoreboard bench: every accepted operation pushes its expected result
//   (plain arithmetic q*d + r) into a queue; a monitor pops and compares on
//   every done pulse and checks that result holds between pulses.
// ---------------------------------------------------------------------------
module tb_div_reconstruct;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] res;
        logic           ov;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   quo;
    logic [W-1:0]   divisor;
    logic [W-1:0]   rem;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
`ifdef DIVCHK_OVF_EN
    logic           ovf;
`endif

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    div_reconstruct #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .quo     (quo),
        .divisor (divisor),
        .rem     (rem),
        .busy    (busy),
        .done    (done),
        .result  (result)
`ifdef DIVCHK_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: dividend = quotient * divisor + remainder.
    function automatic exp_t model(input int q, input int d, input int r);
        exp_t e;
        int   full;
        full  = q * d + r;
        e.res = full[2*W-1:0];
        e.ov  = (full > (2**W - 1)) || (r >= d);
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic           prev_done = 1'b0;
    logic [2*W-1:0] prev_res  = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
            prev_res  = '0;
        end else begin
            if (done) begin
                chk("single_cycle_done", prev_done, 0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: result %0d with empty scoreboard at %0t", result, $time);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
`ifdef DIVCHK_OVF_EN
                    chk("ovf", ovf, e.ov);
`endif
                end
            end else begin
                chk("result_hold", result, prev_res);
            end
            prev_res  = result;
            prev_done = done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy %0d required 0", busy);
        end
    endtask

    // Issue one operation and wait for its done pulse.  Done must appear
    // after the WIDTH-th edge following the accepting edge, with busy high
    // throughout.
    task automatic do_op(input int q, input int d, input int r);
        int k;
        int seen;
        wait_idle();
        @(negedge clk);
        quo     = W'(q);
        divisor = W'(d);
        rem     = W'(r);
        start   = 1'b1;
        sb.push_back(model(q, d, r));
        @(posedge clk);
        #1;
        start   = 1'b0;
        quo     = W'($urandom);
        divisor = W'($urandom);
        rem     = W'($urandom);
        seen    = 0;
        for (k = 1; k <= W + 4; k++) begin
            chk("busy_during_op", busy, 1);
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = k;
                break;
            end
        end
        chk("done_latency", seen, W);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int q, d, r;
        rst     = 1'b1;
        start   = 1'b0;
        quo     = '0;
        divisor = '0;
        rem     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
`ifdef DIVCHK_OVF_EN
        chk("reset_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        do_op(4, 2, 0);
        do_op(0, 7, 1);
        do_op(5, 6, 2);
        do_op(1, 8, 0);
        do_op(7, 10, 0);
        do_op(255, 255, 255);
        do_op(20, 20, 0);
        do_op(1, 6, 7);
        do_op(9, 0, 3);

        // start pulsed with other operands throughout RUN and DONE
        wait_idle();
        @(negedge clk);
        quo = 8'd13; divisor = 8'd11; rem = 8'd5; start = 1'b1;
        sb.push_back(model(13, 11, 5));
        @(posedge clk);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            quo = W'($urandom); divisor = W'($urandom); rem = W'($urandom);
            start = 1'b1;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_starts_drained", sb.size(), 0);

        // asynchronous reset in the middle of RUN
        wait_idle();
        @(negedge clk);
        quo = 8'd200; divisor = 8'd3; rem = 8'd1; start = 1'b1;
        sb.push_back(model(200, 3, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_result", result, 0);
`ifdef DIVCHK_OVF_EN
        chk("midrun_rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("no_done_after_rst", sb.size(), 0);
        do_op(17, 9, 4);

        // random operations
        for (int i = 0; i < 30; i++) begin
            q = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            r = $urandom_range(0, 255);
            do_op(q, d, r);
        end

        // back-to-back with start held high: accepts every W+2 edges
        wait_idle();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            q = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            r = $urandom_range(0, 255);
            quo = W'(q); divisor = W'(d); rem = W'(r); start = 1'b1;
            sb.push_back(model(q, d, r));
            @(posedge clk);
            for (int k = 0; k < W + 1; k++) begin
                @(negedge clk);
                quo = W'($urandom); divisor = W'($urandom); rem = W'($urandom);
                @(posedge clk);
            end
        end
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
